// File: rtl/wb_burst_drain.sv
`default_nettype none
// ============================================================================
// Module   : wb_burst_drain
// Purpose  : Drains {addr,data} entries from an FWFT FIFO as Wishbone classic
//            writes, holding cyc across bursts of up to BURST_LEN beats.
// Revision : 1.0
// ============================================================================
module wb_burst_drain #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int LVL_W     = 4,
    parameter int THRESH    = 4,
    parameter int BURST_LEN = 4,
    parameter int TIMEOUT   = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fifo_empty,
    input  logic [LVL_W-1:0]         fifo_level,
    input  logic [ADDR_W+DATA_W-1:0] fifo_dout,
    output logic                     fifo_rd_en,
    input  logic                     flush_in,
    input  logic                     stall_in,
    output logic                     wb_cyc_o,
    output logic                     wb_stb_o,
    output logic                     wb_we_o,
    output logic [ADDR_W-1:0]        wb_adr_o,
    output logic [DATA_W-1:0]        wb_dat_o,
    input  logic                     wb_ack_i,
    input  logic                     wb_err_i,
    output logic                     busy_o,
    output logic                     err_o,
    input  logic                     err_clr_i
);

    localparam int BC_W = $clog2(BURST_LEN + 1);
    localparam int TO_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_BUS  = 2'd2;

    localparam logic [BC_W-1:0]  BEAT_MAX   = BC_W'(BURST_LEN);
    localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT - 1);
    localparam logic [LVL_W-1:0] THRESH_LVL = LVL_W'(THRESH);

    logic [1:0]      r_state;
    logic [BC_W-1:0] r_beat_cnt;
    logic [TO_W-1:0] r_to_cnt;

    logic w_start;
    logic w_continue;
    logic w_timeout;
    logic w_err_set;

    assign w_start    = !stall_in && !fifo_empty && ((fifo_level >= THRESH_LVL) || flush_in);
    assign w_continue = (r_beat_cnt < BEAT_MAX) && !fifo_empty && !stall_in;
    assign w_timeout  = !wb_ack_i && !wb_err_i && (r_to_cnt == TO_LAST);
    assign w_err_set  = (r_state == S_BUS) && (wb_err_i || w_timeout);

    // Outputs decode straight from state so an async reset drops cyc at once.
    assign wb_cyc_o   = (r_state == S_BUS) || ((r_state == S_LOAD) && (r_beat_cnt != '0));
    assign wb_stb_o   = (r_state == S_BUS);
    assign wb_we_o    = (r_state == S_BUS);
    assign fifo_rd_en = (r_state == S_LOAD);
    assign busy_o     = (r_state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_beat_cnt <= '0;
            r_to_cnt   <= '0;
            wb_adr_o   <= '0;
            wb_dat_o   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state    <= S_LOAD;
                        r_beat_cnt <= '0;
                    end
                end
                S_LOAD: begin
                    wb_adr_o   <= fifo_dout[ADDR_W+DATA_W-1:DATA_W];
                    wb_dat_o   <= fifo_dout[DATA_W-1:0];
                    r_beat_cnt <= r_beat_cnt + 1'b1;
                    r_to_cnt   <= '0;
                    r_state    <= S_BUS;
                end
                S_BUS: begin
                    // An error wins over a simultaneous ack; the beat is dropped.
                    if (wb_err_i) begin
                        r_state <= S_IDLE;
                    end else if (wb_ack_i) begin
                        r_state <= w_continue ? S_LOAD : S_IDLE;
                    end else if (r_to_cnt == TO_LAST) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A new error in the same cycle as a clear request keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_o <= 1'b0;
        end else if (w_err_set) begin
            err_o <= 1'b1;
        end else if (err_clr_i && (r_state != S_LOAD)) begin
            err_o <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_burst_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_burst_drain
// Purpose  : Directed bench for wb_burst_drain with a write scoreboard.
// Revision : 1.0
// ============================================================================
module tb_wb_burst_drain;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fifo_empty;
    logic [LW-1:0] fifo_level;
    logic [63:0]   fifo_dout;
    logic          fifo_rd_en;
    logic          flush_in = 1'b0;
    logic          stall_in = 1'b0;
    logic          wb_cyc_o, wb_stb_o, wb_we_o;
    logic [AW-1:0] wb_adr_o;
    logic [DW-1:0] wb_dat_o;
    logic          wb_ack_i, wb_err_i;
    logic          busy_o, err_o;
    logic          err_clr_i = 1'b0;

    always #5 clk = ~clk;

    wb_burst_drain #(
        .DATA_W(DW), .ADDR_W(AW), .LVL_W(LW),
        .THRESH(4), .BURST_LEN(4), .TIMEOUT(15)
    ) dut (
        .clk(clk), .rst(rst),
        .fifo_empty(fifo_empty), .fifo_level(fifo_level), .fifo_dout(fifo_dout),
        .fifo_rd_en(fifo_rd_en), .flush_in(flush_in), .stall_in(stall_in),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .busy_o(busy_o), .err_o(err_o), .err_clr_i(err_clr_i)
    );

    // FWFT FIFO model
    logic [63:0] mem [16];
    logic [7:0]  wr_ptr = 8'd0;
    logic [7:0]  rd_ptr = 8'd0;
    int          pops = 0;
    int          beats_done = 0;
    logic        ack_en = 1'b0;
    int          err_at = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_level = LW'(wr_ptr - rd_ptr);
    assign fifo_dout  = mem[rd_ptr[3:0]];

    // Slave: acks on the first stb cycle when enabled; err on a chosen beat.
    assign wb_ack_i = wb_stb_o && ack_en;
    assign wb_err_i = wb_stb_o && (err_at != 0) && (beats_done + 1 == err_at);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            rd_ptr <= rd_ptr + 8'd1;
            pops   <= pops + 1;
        end
        if (wb_stb_o && (wb_ack_i || wb_err_i))
            beats_done <= beats_done + 1;
    end

    int          total = 0;
    int          bad = 0;
    logic [63:0] exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input bit expect_wr);
        mem[wr_ptr[3:0]] = {a, d};
        wr_ptr = wr_ptr + 8'd1;
        if (expect_wr) exp_q.push_back({a, d});
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        tick();
        while (busy_o && n < 60) begin
            tick();
            n++;
        end
        check({name, "_idle"}, 64'(busy_o), 64'd0);
    endtask

    task automatic wait_stb(input string name);
        int n;
        n = 0;
        tick();
        while (!wb_stb_o && n < 60) begin
            tick();
            n++;
        end
        check({name, "_stb_seen"}, 64'(wb_stb_o), 64'd1);
    endtask

    // Monitor: every completed (acked, non-error) write is matched in order.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (wb_stb_o && wb_ack_i && !wb_err_i) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got adr 0x%0h dat 0x%0h expected none", wb_adr_o, wb_dat_o);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_adr", 64'(wb_adr_o), 64'(e[63:32]));
                    check("wr_dat", 64'(wb_dat_o), 64'(e[31:0]));
                    check("wr_we", 64'(wb_we_o), 64'd1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int       p0;
        int       n_stb;
        logic [7:0] stb_pat, cyc_pat;

        repeat (3) tick();
        check("rst_cyc", 64'(wb_cyc_o), 64'd0);
        check("rst_stb", 64'(wb_stb_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        check("rst_adr", 64'(wb_adr_o), 64'd0);
        check("rst_dat", 64'(wb_dat_o), 64'd0);
        check("rst_rd_en", 64'(fifo_rd_en), 64'd0);
        rst = 1'b0;
        tick();

        // Level-4 burst in one cyc tenure
        p0 = pops;
        ack_en = 1'b1;
        for (int i = 0; i < 4; i++) push(32'h1000 + 32'(4 * i), 32'hD0 + 32'(i), 1'b1);
        stb_pat = 8'h00;
        cyc_pat = 8'h00;
        for (int i = 0; i < 8; i++) begin
            tick();
            stb_pat = {stb_pat[6:0], wb_stb_o};
            cyc_pat = {cyc_pat[6:0], wb_cyc_o};
        end
        tick();
        check("t1_stb_pattern", 64'(stb_pat), 64'h55);
        check("t1_cyc_pattern", 64'(cyc_pat), 64'h7F);
        check("t1_cyc_end", 64'(wb_cyc_o), 64'd0);
        check("t1_pops", 64'(pops - p0), 64'd4);

        // Below threshold: nothing until flush
        p0 = pops;
        push(32'h100, 32'hA, 1'b1);
        push(32'h104, 32'hB, 1'b1);
        repeat (4) tick();
        check("t2_noflush_busy", 64'(busy_o), 64'd0);
        check("t2_noflush_pops", 64'(pops - p0), 64'd0);
        flush_in = 1'b1;
        wait_idle("t2");
        flush_in = 1'b0;
        check("t2_pops", 64'(pops - p0), 64'd2);

        // Ack timeout
        ack_en = 1'b0;
        flush_in = 1'b1;
        push(32'h200, 32'h55, 1'b0);
        n_stb = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (wb_stb_o) n_stb++;
        end
        flush_in = 1'b0;
        check("t3_stb_cycles", 64'(n_stb), 64'd15);
        check("t3_cyc", 64'(wb_cyc_o), 64'd0);
        check("t3_err", 64'(err_o), 64'd1);
        check("t3_busy", 64'(busy_o), 64'd0);
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        check("t3_err_clr", 64'(err_o), 64'd0);

        // err together with ack on beat 2 of 4
        ack_en = 1'b1;
        err_at = beats_done + 2;
        p0 = pops;
        push(32'h300, 32'h31, 1'b1);
        push(32'h304, 32'h32, 1'b0);
        push(32'h308, 32'h33, 1'b0);
        push(32'h30C, 32'h34, 1'b0);
        wait_idle("t4");
        check("t4_err", 64'(err_o), 64'd1);
        check("t4_cyc", 64'(wb_cyc_o), 64'd0);
        check("t4_pops", 64'(pops - p0), 64'd2);
        check("t4_level", 64'(fifo_level), 64'd2);
        repeat (5) tick();
        check("t4_pops_hold", 64'(pops - p0), 64'd2);
        err_at = 0;
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        check("t4_err_clr", 64'(err_o), 64'd0);
        exp_q.push_back({32'h308, 32'h33});
        exp_q.push_back({32'h30C, 32'h34});
        flush_in = 1'b1;
        wait_idle("t4_drain");
        flush_in = 1'b0;
        check("t4_drain_pops", 64'(pops - p0), 64'd4);

        // Stall raised during beat 1 of a level-8 burst
        p0 = pops;
        for (int i = 0; i < 8; i++) push(32'h400 + 32'(4 * i), 32'h40 + 32'(i), 1'b1);
        wait_stb("t5");
        stall_in = 1'b1;
        tick();
        check("t5_cyc", 64'(wb_cyc_o), 64'd0);
        check("t5_busy", 64'(busy_o), 64'd0);
        repeat (5) tick();
        check("t5_stalled_pops", 64'(pops - p0), 64'd1);
        stall_in = 1'b0;
        tick();
        check("t5_rel_load_busy", 64'(busy_o), 64'd1);
        check("t5_rel_load_stb", 64'(wb_stb_o), 64'd0);
        tick();
        check("t5_rel_stb", 64'(wb_stb_o), 64'd1);
        wait_idle("t5_burst");
        check("t5_burst_pops", 64'(pops - p0), 64'd5);
        flush_in = 1'b1;
        wait_idle("t5_drain");
        flush_in = 1'b0;
        check("t5_drain_pops", 64'(pops - p0), 64'd8);

        // Asynchronous reset mid-BUS
        ack_en = 1'b0;
        flush_in = 1'b1;
        push(32'h500, 32'h77, 1'b0);
        wait_stb("t6");
        tick();
        #1 rst = 1'b1;
        #1;
        check("t6_cyc", 64'(wb_cyc_o), 64'd0);
        check("t6_stb", 64'(wb_stb_o), 64'd0);
        check("t6_busy", 64'(busy_o), 64'd0);
        flush_in = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check("t6_post_busy", 64'(busy_o), 64'd0);
        ack_en = 1'b1;
        p0 = pops;
        push(32'h600, 32'h61, 1'b1);
        push(32'h604, 32'h62, 1'b1);
        flush_in = 1'b1;
        wait_idle("t6_resume");
        flush_in = 1'b0;
        check("t6_resume_pops", 64'(pops - p0), 64'd2);

        repeat (3) tick();
        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_burst_drain.md
Name: wb_burst_drain

Overview:
- Parametrised successor to the FIFO-to-bus drain controller in the CPU memory path.
- Pops {address, data} entries from an external first-word-fall-through (FWFT) write FIFO and issues Wishbone classic write cycles.
- Groups up to BURST_LEN beats under one held cyc, with level-threshold start, flush and stall gating, ack-timeout detection and sticky error reporting.

Parameters:
- DATA_W, 32, Wishbone data width.
- ADDR_W, 32, Wishbone address width.
- LVL_W, 4, width of fifo_level.
- THRESH, 4, FIFO level that starts a burst without flush.
- BURST_LEN, 4, maximum beats per cyc tenure (>=1).
- TIMEOUT, 15, cycles in BUS without ack/err before abort (>=1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- fifo_empty  in  1  FIFO empty flag.
- fifo_level  in  LVL_W  current FIFO occupancy.
- fifo_dout  in  ADDR_W+DATA_W  FWFT head entry, {addr, data}; valid while !fifo_empty.
- fifo_rd_en  out  1  pop strobe; head consumed at this edge.
- flush_in  in  1  drain regardless of THRESH.
- stall_in  in  1  pipeline stall; blocks new bursts and burst continuation.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_stb_o  out  1  Wishbone strobe.
- wb_we_o  out  1  write enable.
- wb_adr_o  out  ADDR_W  registered address.
- wb_dat_o  out  DATA_W  registered write data.
- wb_ack_i  in  1  Wishbone acknowledge.
- wb_err_i  in  1  Wishbone error.
- busy_o  out  1  state != IDLE.
- err_o  out  1  sticky error flag.
- err_clr_i  in  1  clears err_o.

Behaviour:
- Reset (async, any state, mid-burst included):
  - state=IDLE; all outputs 0, including wb_adr_o/wb_dat_o.
  - beat_cnt=0, to_cnt=0, err_o=0.
  - wb_cyc_o drops immediately, not at the next edge.
- States: IDLE, LOAD, BUS.
- IDLE:
  - Start condition: !stall_in && !fifo_empty && (fifo_level>=THRESH || flush_in).
  - On start -> LOAD, beat_cnt=0.
- LOAD (exactly 1 cycle):
  - fifo_rd_en=1; wb_adr_o<=fifo_dout[ADDR_W+DATA_W-1:DATA_W]; wb_dat_o<=fifo_dout[DATA_W-1:0].
  - beat_cnt++; to_cnt=0 -> BUS.
  - wb_cyc_o=1 if beat_cnt>0 at entry (cyc held across a burst); otherwise 0. wb_stb_o=0.
- BUS:
  - wb_cyc_o=wb_stb_o=wb_we_o=1; to_cnt increments each cycle without ack/err.
  - wb_err_i=1 (takes priority over simultaneous ack) -> err_o<=1, -> IDLE; the beat is lost, not retried.
  - to_cnt==TIMEOUT-1 with no ack/err -> err_o<=1, -> IDLE.
  - wb_ack_i=1:
    - If beat_cnt<BURST_LEN && !fifo_empty && !stall_in -> LOAD (cyc stays high).
    - Otherwise -> IDLE (cyc low next cycle).
  - flush_in is not required to continue a burst; level is only checked at start.
- fifo_rd_en is asserted only in LOAD, so no pop occurs while fifo_empty (guaranteed by the transition conditions).
- err_o:
  - Set as above; cleared by err_clr_i in IDLE or BUS.
  - A set in the same cycle as err_clr_i wins.
- Minimum latency: start condition to first stb = 2 edges. Back-to-back beats = 1 bubble cycle (LOAD) between stb pulses.
- Counters: beat_cnt width clog2(BURST_LEN+1); to_cnt width clog2(TIMEOUT+1). Neither wraps, because transitions occur before the limit is reached.

Test Plan:
- Level 4, THRESH=4, slave acks the first cycle of each stb:
  - Required: 4 writes in a single cyc tenure; stb pattern 0,1,0,1,0,1,0,1; cyc low after the 4th ack; fifo_rd_en pulses 4.
- Level 2, flush_in=1, entries {0x100,0xA}, {0x104,0xB}:
  - Required: two beats with adr/dat matching, then IDLE; with flush_in=0 no cycle starts.
- Slave never acks, TIMEOUT=15:
  - Required: stb high exactly 15 cycles, then cyc=0 and err_o=1.
  - Pulse err_clr_i: err_o=0.
- wb_err_i and wb_ack_i asserted together on beat 2 of 4:
  - Required: err_o=1, cyc drops, remaining 2 entries stay in the FIFO (no further pops).
- stall_in raised during BUS of beat 1, level 8:
  - Required: beat 1 completes on ack, cyc drops, no LOAD while stalled.
  - On stall release: new burst starts after 2 edges.
- rst asserted asynchronously mid-BUS:
  - Required: wb_cyc_o/wb_stb_o go to 0 before the next clk edge; busy_o=0; after release, normal operation resumes from IDLE.
